// File: rtl/adder_operand_loader.sv
// adder_operand_loader
//
// Assembles two WIDTH-bit operands from a little-endian byte stream, presents
// them to an external combinational adder, captures the adder result into
// registers, and hands it to a consumer. The block holds one operation at a time.
//
// Ports
//   clk, rst          clock and asynchronous active-high reset
//   in_data/in_cin    operand byte stream and carry-in (carry-in taken with byte 0 of A)
//   in_valid/in_ready byte handshake
//   op_A/op_B/op_Cin  assembled operands to the adder, qualified by op_valid
//   op_valid/op_ready operand handshake
//   sum_i/cout_i/ovf_i combinational adder result
//   res_SUM/res_Cout/res_Overflow  registered result, qualified by res_valid
//   res_valid/res_ready result handshake
module adder_operand_loader #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] op_A,
    output logic [WIDTH-1:0] op_B,
    output logic             op_Cin,
    output logic             op_valid,
    input  logic             op_ready,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    input  logic             ovf_i,
    output logic [WIDTH-1:0] res_SUM,
    output logic             res_Cout,
    output logic             res_Overflow,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam int unsigned NumBytes = WIDTH / 8;
    localparam int unsigned CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumBytes - 1);

    typedef enum logic [1:0] {
        StLoadA,
        StLoadB,
        StIssue,
        StResult
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic             res_ovf_q, res_ovf_d;

    logic             loading;
    logic             accept;
    logic             last_byte;
    logic [CntW+2:0]  bit_base;

    // in_ready is forced low for the whole reset pulse, not only after the clock.
    assign loading   = (state_q == StLoadA) || (state_q == StLoadB);
    assign in_ready  = loading && !rst;
    assign accept    = in_valid && in_ready;
    assign last_byte = (cnt_q == LastCnt);
    assign bit_base  = {cnt_q, 3'b000};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_cin_d   = op_cin_q;
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        res_ovf_d  = res_ovf_q;

        case (state_q)
            StLoadA: begin
                if (accept) begin
                    op_a_d[bit_base +: 8] = in_data;
                    if (cnt_q == '0) begin
                        op_cin_d = in_cin;
                    end
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = StLoadB;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StLoadB: begin
                if (accept) begin
                    op_b_d[bit_base +: 8] = in_data;
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = StIssue;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StIssue: begin
                // Adder output is combinational from the held operands, so it
                // is valid on the handshake cycle itself.
                if (op_ready) begin
                    res_sum_d  = sum_i;
                    res_cout_d = cout_i;
                    res_ovf_d  = ovf_i;
                    state_d    = StResult;
                end
            end
            StResult: begin
                if (res_ready) begin
                    state_d = StLoadA;
                end
            end
            default: begin
                state_d = StLoadA;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StLoadA;
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_cin_q   <= 1'b0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_cin_q   <= op_cin_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    assign op_A         = op_a_q;
    assign op_B         = op_b_q;
    assign op_Cin       = op_cin_q;
    assign op_valid     = (state_q == StIssue);
    assign res_SUM      = res_sum_q;
    assign res_Cout     = res_cout_q;
    assign res_Overflow = res_ovf_q;
    assign res_valid    = (state_q == StResult);

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for adder_operand_loader at WIDTH=32 with a behavioural adder.
module tb_adder_operand_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_cin;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_A, op_B;
    logic        op_Cin, op_valid, op_ready;
    logic [31:0] sum_i;
    logic        cout_i, ovf_i;
    logic [31:0] res_SUM;
    logic        res_Cout, res_Overflow, res_valid, res_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural downstream adder.
    logic [32:0] full_sum;
    assign full_sum = {1'b0, op_A} + {1'b0, op_B} + {32'd0, op_Cin};
    assign sum_i    = full_sum[31:0];
    assign cout_i   = full_sum[32];
    assign ovf_i    = (op_A[31] == op_B[31]) && (full_sum[31] != op_A[31]);

    adder_operand_loader #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_cin       (in_cin),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_A         (op_A),
        .op_B         (op_B),
        .op_Cin       (op_Cin),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .sum_i        (sum_i),
        .cout_i       (cout_i),
        .ovf_i        (ovf_i),
        .res_SUM      (res_SUM),
        .res_Cout     (res_Cout),
        .res_Overflow (res_Overflow),
        .res_valid    (res_valid),
        .res_ready    (res_ready)
    );

    task automatic send_byte(input logic [7:0] d, input logic c);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = d;
        in_cin   = c;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends operand bytes from index 'first'; in_cin is the wanted carry only
    // on byte 0 and the inverse elsewhere so stray sampling shows up.
    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input logic [7:0] gap_mask, input int first);
        logic [63:0] v;
        v = {b, a};
        for (int i = first; i < 8; i++) begin
            if (gap_mask[i]) begin
                repeat (2) @(negedge clk);
            end
            send_byte(v[8*i +: 8], (i == 0) ? cin : ~cin);
            if (i == 6) begin
                checks++;
                if ({op_valid, in_ready} !== 2'b01) begin
                    errors++;
                    $display("FAIL pre_last_byte: op_valid,in_ready=%b required 01",
                             {op_valid, in_ready});
                end
            end
            if (i == 7) begin
                checks++;
                if ({op_valid, in_ready} !== 2'b10) begin
                    errors++;
                    $display("FAIL op_valid_after_last: op_valid,in_ready=%b required 10",
                             {op_valid, in_ready});
                end
            end
        end
    endtask

    task automatic issue_and_result(input logic [31:0] ea, input logic [31:0] eb,
                                    input logic ecin, input logic [31:0] esum,
                                    input logic ecout, input logic eovf,
                                    input int op_stall, input int res_stall);
        for (int i = 0; i < op_stall; i++) begin
            @(negedge clk);
            checks++;
            if ({op_valid, in_ready, op_A, op_B, op_Cin} !== {2'b10, ea, eb, ecin}) begin
                errors++;
                $display("FAIL op_stall[%0d]: got v=%b r=%b A=%h B=%h C=%b required 1 0 %h %h %b",
                         i, op_valid, in_ready, op_A, op_B, op_Cin, ea, eb, ecin);
            end
        end
        @(negedge clk);
        checks++;
        if ({op_valid, op_A, op_B, op_Cin} !== {1'b1, ea, eb, ecin}) begin
            errors++;
            $display("FAIL operands: got v=%b A=%h B=%h C=%b required 1 %h %h %b",
                     op_valid, op_A, op_B, op_Cin, ea, eb, ecin);
        end
        op_ready = 1'b1;
        @(posedge clk);
        #1;
        op_ready = 1'b0;
        checks++;
        if ({res_valid, op_valid, res_SUM, res_Cout, res_Overflow} !==
            {2'b10, esum, ecout, eovf}) begin
            errors++;
            $display("FAIL result: got rv=%b ov=%b S=%h Co=%b Ov=%b required 1 0 %h %b %b",
                     res_valid, op_valid, res_SUM, res_Cout, res_Overflow, esum, ecout, eovf);
        end
        for (int i = 0; i < res_stall; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, in_ready, res_SUM, res_Cout, res_Overflow} !==
                {2'b10, esum, ecout, eovf}) begin
                errors++;
                $display("FAIL res_stall[%0d]: got rv=%b r=%b S=%h Co=%b Ov=%b required 1 0 %h",
                         i, res_valid, in_ready, res_SUM, res_Cout, res_Overflow, esum);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checks++;
        if ({res_valid, in_ready, res_SUM, res_Cout, res_Overflow} !==
            {2'b01, esum, ecout, eovf}) begin
            errors++;
            $display("FAIL res_release: got rv=%b r=%b S=%h Co=%b Ov=%b required 0 1 %h %b %b",
                     res_valid, in_ready, res_SUM, res_Cout, res_Overflow, esum, ecout, eovf);
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({op_A, op_B, op_Cin, op_valid, res_SUM, res_Cout, res_Overflow, res_valid,
             in_ready} !== '0) begin
            errors++;
            $display("FAIL %s_async: A=%h B=%h C=%b v=%b S=%h Co=%b Ov=%b rv=%b r=%b required all 0",
                     tag, op_A, op_B, op_Cin, op_valid, res_SUM, res_Cout, res_Overflow,
                     res_valid, in_ready);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: in_ready=%b required 1", tag, in_ready);
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({op_A, op_B, op_Cin, op_valid, res_SUM, res_Cout, res_Overflow, res_valid,
             in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state: A=%h B=%h v=%b S=%h rv=%b r=%b required all 0",
                     op_A, op_B, op_valid, res_SUM, res_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, op_valid, res_valid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: r,v,rv=%b required 100", {in_ready, op_valid, res_valid});
        end
    endtask

    task automatic test_basic;
        send_op(32'h0000_0001, 32'h0000_0002, 1'b0, 8'h00, 0);
        issue_and_result(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_overflow;
        send_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 8'h00, 0);
        issue_and_result(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 0);
    endtask

    task automatic test_carry;
        send_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 8'h00, 0);
        issue_and_result(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_op_stall;
        send_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 8'h00, 0);
        issue_and_result(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 5, 0);
    endtask

    task automatic test_reset_mid_load;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        pulse_reset("rst_mid_load");
        send_op(32'h1111_1111, 32'h2222_2222, 1'b1, 8'h00, 0);
        issue_and_result(32'h1111_1111, 32'h2222_2222, 1'b1, 32'h3333_3334, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_issue;
        send_op(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 8'h00, 0);
        pulse_reset("rst_mid_issue");
        send_op(32'h0000_0005, 32'h0000_0006, 1'b0, 8'h00, 0);
        issue_and_result(32'h0000_0005, 32'h0000_0006, 1'b0, 32'h0000_000B, 1'b0, 1'b0, 0, 0);
    endtask

    // Next operation's first byte is offered while the result is stalled; it
    // must be accepted exactly once, after the result handshake.
    task automatic test_back_to_back;
        send_op(32'h8000_0000, 32'h8000_0000, 1'b0, 8'hA5, 0);
        @(negedge clk);
        in_data  = 8'h04;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        issue_and_result(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0, 4);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send_op(32'h0102_0304, 32'h0A0B_0C0D, 1'b1, 8'h5A, 1);
        issue_and_result(32'h0102_0304, 32'h0A0B_0C0D, 1'b1, 32'h0B0D_0F12, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_cin    = 1'b0;
        in_valid  = 1'b0;
        op_ready  = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_carry();
        test_op_stall();
        test_reset_mid_load();
        test_reset_mid_issue();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_operand_loader.md
ADDER_OPERAND_LOADER -- requirements
Module: adder_operand_loader

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; SHALL be a multiple of 8, at least 8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_data  input  8  serial operand byte stream.
REQ-005 in_cin  input  1  carry-in; sampled with the first byte of A.
REQ-006 in_valid  input  1  in_data/in_cin valid.
REQ-007 in_ready  output  1  loader accepts a byte this cycle.
REQ-008 op_A  output  WIDTH  assembled operand A to downstream adder.
REQ-009 op_B  output  WIDTH  assembled operand B to downstream adder.
REQ-010 op_Cin  output  1  captured carry-in to downstream adder.
REQ-011 op_valid  output  1  op_A/op_B/op_Cin valid.
REQ-012 op_ready  input  1  adder side accepts operands.
REQ-013 sum_i  input  WIDTH  adder SUM, combinational from op_A/op_B/op_Cin.
REQ-014 cout_i  input  1  adder carry-out.
REQ-015 ovf_i  input  1  adder signed overflow.
REQ-016 res_SUM  output  WIDTH  registered sum.
REQ-017 res_Cout  output  1  registered carry-out.
REQ-018 res_Overflow  output  1  registered overflow.
REQ-019 res_valid  output  1  result registers valid.
REQ-020 res_ready  input  1  consumer accepts result.

Function
REQ-021 FSM states SHALL be LOAD_A, LOAD_B, ISSUE, RESULT; byte counter 0..WIDTH/8-1.
REQ-022 in_ready SHALL be 1 exactly in LOAD_A and LOAD_B; byte accepted only when in_valid & in_ready.
REQ-023 Bytes SHALL be little-endian: byte k of an operand lands in bits [8k+7:8k].
REQ-024 LOAD_A: first accepted byte (count 0) SHALL also capture in_cin into op_Cin; after WIDTH/8 bytes, counter clears, state -> LOAD_B.
REQ-025 LOAD_B: after WIDTH/8 bytes, counter clears, state -> ISSUE; op_valid high the cycle after the last byte is accepted.
REQ-026 in_valid low SHALL stall loading with no state, counter or operand change.
REQ-027 ISSUE: op_valid=1; op_A/op_B/op_Cin SHALL be stable until op_valid & op_ready.
REQ-028 On the op handshake cycle, sum_i/cout_i/ovf_i SHALL be captured into res_*; state -> RESULT; res_valid high the next cycle.
REQ-029 RESULT: res_valid=1, res_* stable until res_valid & res_ready; then state -> LOAD_A, res_valid low next cycle.
REQ-030 No overlap: no new byte accepted while in ISSUE or RESULT (single-buffered).
REQ-031 op_A/op_B/op_Cin SHALL hold their last values outside ISSUE; only op_valid qualifies them.
REQ-032 res_* SHALL hold last captured values after handshake until the next capture.
REQ-033 No arithmetic in this block; result fields SHALL be passed through unmodified, width WIDTH.

Reset
REQ-034 rst=1 SHALL immediately, without clock, force state LOAD_A, counter 0, all outputs 0 except in_ready=1 once rst deasserts; in_ready=0 while rst=1.
REQ-035 rst mid-load, mid-ISSUE or mid-RESULT SHALL discard partial operands and results; next 2*WIDTH/8 accepted bytes form a fresh operation.

Verification (WIDTH=32)
REQ-036 Bytes 01,00,00,00,02,00,00,00, in_cin=0, adder model -> op_A=0x00000001, op_B=0x00000002, op_valid 1 cycle after 8th byte; res_SUM=0x00000003, res_Cout=0, res_Overflow=0.
REQ-037 A=0x7FFFFFFF, B=0x00000001, cin=0 -> res_SUM=0x80000000, res_Overflow=1, res_Cout=0.
REQ-038 A=0xFFFFFFFF, B=0x00000000, cin=1 (on first A byte only) -> op_Cin=1, res_SUM=0x00000000, res_Cout=1.
REQ-039 op_ready low 5 cycles in ISSUE -> op_valid held 1, op_A/op_B/op_Cin unchanged, in_ready=0 throughout.
REQ-040 rst pulsed after 3 A bytes -> all outputs 0 asynchronously, next 8 bytes yield fresh correct operands.
REQ-041 res_ready low 4 cycles, in_valid random gaps during loading -> res_* stable, in_ready=0 until result handshake, no byte lost or duplicated.
